// File: rtl/fifo_frame_reader_if.sv
// Read-side FIFO handshake plus framed payload stream for fifo_frame_reader.
// master is the frame reader itself; slave is the FIFO/downstream environment.
interface fifo_frame_reader_if #(
    parameter int DATA_LEN  = 16,
    parameter int CNT_WIDTH = 16
);
    logic                 fifo_empty;
    logic [DATA_LEN-1:0]  fifo_data;
    logic                 fifo_read_en;
    logic [DATA_LEN-1:0]  out_data;
    logic                 out_valid;
    logic                 out_last;
    logic                 out_ready;
    logic                 frame_err;
    logic [CNT_WIDTH-1:0] frame_count;

    modport master (
        input  fifo_empty, fifo_data, out_ready,
        output fifo_read_en, out_data, out_valid, out_last, frame_err, frame_count
    );

    modport slave (
        output fifo_empty, fifo_data, out_ready,
        input  fifo_read_en, out_data, out_valid, out_last, frame_err, frame_count
    );
endinterface

// File: rtl/fifo_frame_reader.sv
// Drains async_fifo's read side, strips a tag/length header per frame and emits the
// payload on a valid/ready stream with out_last, counting frames and flagging bad headers.
module fifo_frame_reader #(
    parameter int          DATA_LEN  = 16,
    parameter logic [7:0]  HDR_TAG   = 8'hA5,
    parameter int          MAX_LEN   = 255,
    parameter int          CNT_WIDTH = 16
) (
    input  logic                rd_clk,
    input  logic                reset_n,
    fifo_frame_reader_if.master bus
);

    typedef enum logic {HUNT, PAYLOAD} state_t;

    localparam logic [7:0] MAX_LEN_B = 8'(MAX_LEN);

    state_t               state_q;
    logic [7:0]           cnt_q;
    logic [1:0]           occ_q;
    logic                 inflight_q;
    logic                 frame_err_q;
    logic [CNT_WIDTH-1:0] frame_count_q;
    logic [DATA_LEN-1:0]  head_q;
    logic [DATA_LEN-1:0]  tail_q;

    logic       has_head;
    logic       out_valid_c;
    logic       pop;
    logic [1:0] level;
    logic [1:0] wr_slot;
    logic       read_en;
    logic       hdr_ok;

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        has_head    = 1'b0;
        out_valid_c = 1'b0;
        pop         = 1'b0;
        level       = 2'd0;
        wr_slot     = 2'd0;
        read_en     = 1'b0;
        hdr_ok      = 1'b0;

        has_head    = (occ_q != 2'd0);
        out_valid_c = (state_q == PAYLOAD) && has_head;
        // In HUNT the header is swallowed internally; in PAYLOAD only a handshake frees the head.
        pop         = (state_q == HUNT) ? has_head : (out_valid_c && bus.out_ready);
        level       = occ_q + {1'b0, inflight_q} - {1'b0, pop};
        wr_slot     = occ_q - {1'b0, pop};
        read_en     = reset_n && !bus.fifo_empty && (level < 2'd2);
        hdr_ok      = (head_q[DATA_LEN-1 -: 8] == HDR_TAG) &&
                      (head_q[7:0] != 8'd0) && (head_q[7:0] <= MAX_LEN_B);
    end

    assign bus.fifo_read_en = read_en;
    assign bus.out_valid    = out_valid_c;
    assign bus.out_data     = out_valid_c ? head_q : '0;
    assign bus.out_last     = out_valid_c && (cnt_q == 8'd1);
    assign bus.frame_err    = frame_err_q;
    assign bus.frame_count  = frame_count_q;

    // NOTE: skid data registers are not reset; occ_q qualifies them and out_data is gated by out_valid.
    always_ff @(posedge rd_clk) begin
        if (pop) begin
            head_q <= tail_q;
        end
        // The returned word lands after the shift, so a later write to head_q wins on push+pop.
        if (inflight_q) begin
            if (wr_slot == 2'd0) begin
                head_q <= bus.fifo_data;
            end else begin
                tail_q <= bus.fifo_data;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every register sees pre-edge values.
    always_ff @(posedge rd_clk) begin
        if (!reset_n) begin
            state_q       <= HUNT;
            cnt_q         <= 8'd0;
            occ_q         <= 2'd0;
            inflight_q    <= 1'b0;
            frame_err_q   <= 1'b0;
            frame_count_q <= '0;
        end else begin
            occ_q       <= level;
            inflight_q  <= read_en;
            frame_err_q <= 1'b0;
            case (state_q)
                HUNT: begin
                    if (has_head) begin
                        if (hdr_ok) begin
                            cnt_q   <= head_q[7:0];
                            state_q <= PAYLOAD;
                        end else begin
                            frame_err_q <= 1'b1;
                        end
                    end
                end
                PAYLOAD: begin
                    if (pop) begin
                        cnt_q <= cnt_q - 8'd1;
                        if (cnt_q == 8'd1) begin
                            frame_count_q <= frame_count_q + 1'b1;
                            state_q       <= HUNT;
                        end
                    end
                end
                default: state_q <= HUNT;
            endcase
        end
    end

endmodule

// File: doc/fifo_frame_reader.md
Name: fifo_frame_reader

Overview:
- Drains the read side of async_fifo in the rd_clk domain and turns the raw 16-bit word stream into framed payload on a valid/ready output stream.
- Each frame in the FIFO is one header word followed by N payload words.
- The block strips the header, flags the last payload word, counts completed frames and rejects malformed headers.
- A 2-entry skid buffer absorbs the FIFO's 1-cycle read latency, so the output sustains 1 word/cycle.

Parameters:
- DATA_LEN, 16, word width; must match async_fifo DATA_LEN; header layout below assumes 16.
- HDR_TAG, 8'hA5, required value of header bits [15:8].
- MAX_LEN, 255, largest legal payload length; 1..255.
- CNT_WIDTH, 16, width of frame_count.

Ports:
- rd_clk  input  1  block clock; same clock as async_fifo rd_clk.
- reset_n  input  1  synchronous, active-low reset.
- fifo_empty  input  1  async_fifo empty flag.
- fifo_data  input  DATA_LEN  async_fifo data_out; valid the cycle after fifo_read_en.
- fifo_read_en  output  1  pop request to async_fifo read_en.
- out_data  output  DATA_LEN  payload word.
- out_valid  output  1  out_data valid.
- out_last  output  1  qualifies the final payload word of a frame.
- out_ready  input  1  downstream accept.
- frame_err  output  1  one-cycle pulse on a rejected header.
- frame_count  output  CNT_WIDTH  number of completed frames; wraps.

Behaviour:
- Interface decided: one clock, rd_clk; reset_n synchronous, active-low.
- Reset (reset_n=0 at a rd_clk edge):
  - fifo_read_en=0, out_valid=0, out_last=0, out_data=0, frame_err=0, frame_count=0.
  - Skid buffer emptied; state=HUNT; payload counter=0.
  - In-flight read flag cleared; a word returned the cycle after reset is discarded.
  - Reset mid-frame abandons the frame; no out_last and no count increment.
- Read pipeline:
  - fifo_read_en = !fifo_empty && (occ + inflight - pop) < 2, where occ = skid entries, inflight = read issued last cycle, pop = skid head consumed this cycle.
  - A returned word is written to the skid tail one cycle after fifo_read_en.
  - The skid buffer never overflows; simultaneous push and pop is legal at any occupancy.
- State HUNT: the skid head is treated as a header and consumed internally in 1 cycle; it is never presented on out_*.
  - Legal header: [15:8]==HDR_TAG && 1<=[7:0]<=MAX_LEN. Load payload counter with [7:0] and go to PAYLOAD.
  - Illegal header (bad tag or length 0): pulse frame_err for 1 cycle, discard the word, stay in HUNT.
- State PAYLOAD: out_valid=1 whenever the skid is non-empty. out_data is the skid head. out_last=1 when counter==1.
  - Handshake when out_valid && out_ready: pop the head and decrement the counter.
  - On a handshake with out_last=1: frame_count+1 (wraps at 2^CNT_WIDTH), go to HUNT.
  - While out_valid && !out_ready, out_data and out_last are held stable. out_valid never deasserts without a handshake.
  - Payload words are not tag-checked.
- Output registers: out_* driven from the skid head, no combinational path from out_ready to out_valid/out_data. fifo_read_en may depend combinationally on out_ready through pop.
- Throughput:
  - Header costs 1 bubble cycle per frame.
  - Payload runs at 1 word/cycle with out_ready=1 and fifo_empty=0.
  - Latency from the header's fifo_read_en to the first out_valid is 3 cycles.
- fifo_empty asserting mid-frame: out_valid drops once the skid drains; the frame resumes when data returns and state is retained.

Test Plan:
1. Frame 16'hA503, 1, 2, 3, out_ready=1 -> out_data 1, 2, 3 on consecutive cycles; out_last only on 3; frame_count=1; header never on out_data.
2. Backpressure: same frame with out_ready toggling 1/0 per cycle -> out_data/out_last stable while stalled; exactly 3 handshakes; skid never exceeds 2; no word lost or duplicated.
3. Bad headers 16'h1203 then 16'hA500, followed by 16'hA501, 16'hBEEF -> two frame_err pulses; single output 16'hBEEF with out_last=1; frame_count=1.
4. Back-to-back 512 frames of length 1 -> frame_count=512; then 65536 total frames with CNT_WIDTH=16 -> frame_count wraps to 0.
5. fifo_empty asserted after payload word 2 of a length-5 frame for 10 cycles -> out_valid low after the skid drains; words 3..5 follow correctly with out_last on 5.
6. reset_n=0 for 1 cycle mid-payload with a read in flight -> all outputs 0 next cycle, state HUNT, in-flight word discarded; the next header 16'hA502 is framed correctly.
